// File: rtl/ex_alu_stage.sv
// rtl/ex_alu_stage.sv - registered execute-stage ALU with valid/ready writeback beats
//
// Purpose: executes ADD/SUB/MOVE as one writeback beat and SWAP as two beats
// (Rd <- Rs, then Rs <- Rd), holding upstream while a SWAP is in flight.
// Optional condition-flag register, enabled by defining ALU_FLAGS_EN; when it
// is undefined flag_z/flag_c/flag_v are tied to 0.
//
// Ports:
//   clk, reset_n             clock (rising edge), asynchronous active-low reset
//   in_valid, in_ready       ID/EX handshake
//   alu_control              000 ADD, 001 SUB, 010 MOVE, 011 SWAP, 1xx illegal
//   op_a, op_b, rd_a, rd_b   operands (Rd, Rs values) and their register addresses
//   out_valid, out_ready     EX/MEM handshake
//   result, result_rd        writeback data and register address
//   illegal                  beat came from an illegal code
//   flag_z, flag_c, flag_v   zero, carry/borrow, signed overflow
module ex_alu_stage #(
  parameter int WIDTH = 16,
  parameter int RADDR = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       alu_control,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [RADDR-1:0] rd_a,
  input  logic [RADDR-1:0] rd_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [RADDR-1:0] result_rd,
  output logic             illegal,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_v
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_HOLD  = 2'd1;
  localparam logic [1:0] S_SWAP1 = 2'd2;
  localparam logic [1:0] S_SWAP2 = 2'd3;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_MOVE = 3'b010;
  localparam logic [2:0] OP_SWAP = 3'b011;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [WIDTH-1:0] swap_data;
  logic [RADDR-1:0] swap_rd;
  logic             accept;
  logic             consumed;

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] load_result;
  logic             load_illegal;
  logic [1:0]       load_state;

  // SWAP2 deliberately refuses input even when its beat drains: the cycle
  // after a SWAP is always a bubble.
  assign in_ready  = (state == S_IDLE) || ((state == S_HOLD) && out_ready);
  assign out_valid = (state != S_IDLE);
  assign accept    = in_valid && in_ready;
  assign consumed  = out_valid && out_ready;

  assign sum  = op_a + op_b;
  assign diff = op_a - op_b;

  // Beat produced by an accepted operation, and where the FSM goes with it.
  always_comb begin
    load_result  = '0;
    load_illegal = 1'b0;
    load_state   = S_HOLD;
    case (alu_control)
      OP_ADD:  load_result = sum;
      OP_SUB:  load_result = diff;
      OP_MOVE: load_result = op_b;
      OP_SWAP: begin
        load_result = op_b;
        load_state  = S_SWAP1;
      end
      default: load_illegal = 1'b1;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = load_state;
      S_HOLD: begin
        if (accept)        state_nxt = load_state;
        else if (consumed) state_nxt = S_IDLE;
      end
      S_SWAP1: if (consumed) state_nxt = S_SWAP2;
      S_SWAP2: if (consumed) state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      result    <= '0;
      result_rd <= '0;
      illegal   <= 1'b0;
      swap_data <= '0;
      swap_rd   <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        result    <= load_result;
        result_rd <= rd_a;
        illegal   <= load_illegal;
        // Second SWAP beat writes old Rd value into Rs.
        if (alu_control == OP_SWAP) begin
          swap_data <= op_a;
          swap_rd   <= rd_b;
        end
      end else if ((state == S_SWAP1) && consumed) begin
        result    <= swap_data;
        result_rd <= swap_rd;
        illegal   <= 1'b0;
      end
    end
  end

`ifdef ALU_FLAGS_EN
  logic [WIDTH:0] sum_ext;
  logic [WIDTH:0] diff_ext;
  logic           add_v;
  logic           sub_v;

  // The extra MSB of the widened sum is the carry; of the widened difference,
  // the borrow (set exactly when op_a < op_b unsigned).
  assign sum_ext  = {1'b0, op_a} + {1'b0, op_b};
  assign diff_ext = {1'b0, op_a} - {1'b0, op_b};
  assign add_v = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (sum[WIDTH-1]  != op_a[WIDTH-1]);
  assign sub_v = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (diff[WIDTH-1] != op_a[WIDTH-1]);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flag_z <= 1'b0;
      flag_c <= 1'b0;
      flag_v <= 1'b0;
    end else if (accept && (alu_control == OP_ADD)) begin
      flag_z <= (sum == '0);
      flag_c <= sum_ext[WIDTH];
      flag_v <= add_v;
    end else if (accept && (alu_control == OP_SUB)) begin
      flag_z <= (diff == '0);
      flag_c <= diff_ext[WIDTH];
      flag_v <= sub_v;
    end
  end
`else
  assign flag_z = 1'b0;
  assign flag_c = 1'b0;
  assign flag_v = 1'b0;
`endif

endmodule

// File: tb/tb_ex_alu_stage.sv
// tb/tb_ex_alu_stage.sv - self-checking bench for ex_alu_stage
module tb_ex_alu_stage;

  localparam int WIDTH = 16;
  localparam int RADDR = 4;
`ifdef ALU_FLAGS_EN
  localparam bit FLAGS = 1'b1;
`else
  localparam bit FLAGS = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [2:0]       alu_control = 3'b000;
  logic [WIDTH-1:0] op_a = '0;
  logic [WIDTH-1:0] op_b = '0;
  logic [RADDR-1:0] rd_a = '0;
  logic [RADDR-1:0] rd_b = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] result;
  logic [RADDR-1:0] result_rd;
  logic             illegal;
  logic             flag_z;
  logic             flag_c;
  logic             flag_v;

  always #5 clk = ~clk;

  ex_alu_stage #(.WIDTH(WIDTH), .RADDR(RADDR)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .alu_control(alu_control),
    .op_a(op_a), .op_b(op_b), .rd_a(rd_a), .rd_b(rd_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .result_rd(result_rd), .illegal(illegal),
    .flag_z(flag_z), .flag_c(flag_c), .flag_v(flag_v)
  );

  int compared = 0;
  int mismatched = 0;

  // Reference model: a queue of pending writeback beats plus a flag register.
  typedef struct {
    logic [WIDTH-1:0] data;
    logic [RADDR-1:0] rd;
    logic             ill;
    logic             swap_tail;
  } beat_t;

  beat_t      q[$];
  logic [2:0] mf = 3'b000;

  logic             exp_valid;
  logic             exp_ready;
  logic [WIDTH-1:0] exp_data;
  logic [RADDR-1:0] exp_rd;
  logic             exp_ill;
  logic [2:0]       exp_flags;

  task automatic expect_now();
    exp_valid = (q.size() != 0);
    exp_ready = (q.size() == 0) || ((q.size() == 1) && out_ready && !q[0].swap_tail);
    exp_data  = '0;
    exp_rd    = '0;
    exp_ill   = 1'b0;
    if (exp_valid) begin
      exp_data = q[0].data;
      exp_rd   = q[0].rd;
      exp_ill  = q[0].ill;
    end
    exp_flags = FLAGS ? mf : 3'b000;
  endtask

  task automatic model_reset();
    q.delete();
    mf = 3'b000;
  endtask

  task automatic model_step(input logic acc, input logic cons);
    int    a, b, sa, sb, full;
    beat_t bt;
    if (cons) void'(q.pop_front());
    if (acc) begin
      a  = int'(op_a);
      b  = int'(op_b);
      sa = int'($signed(op_a));
      sb = int'($signed(op_b));
      bt.rd = rd_a;
      bt.ill = 1'b0;
      bt.swap_tail = 1'b0;
      case (alu_control)
        3'd0: begin
          full = a + b;
          bt.data = WIDTH'(full % 65536);
          q.push_back(bt);
          mf = {(full % 65536) == 0, full > 65535, (sa + sb > 32767) || (sa + sb < -32768)};
        end
        3'd1: begin
          full = a - b;
          bt.data = WIDTH'((full + 65536) % 65536);
          q.push_back(bt);
          mf = {full == 0, a < b, (sa - sb > 32767) || (sa - sb < -32768)};
        end
        3'd2: begin
          bt.data = op_b;
          q.push_back(bt);
        end
        3'd3: begin
          bt.data = op_b;
          q.push_back(bt);
          bt.data = op_a;
          bt.rd = rd_b;
          bt.swap_tail = 1'b1;
          q.push_back(bt);
        end
        default: begin
          bt.data = '0;
          bt.ill = 1'b1;
          q.push_back(bt);
        end
      endcase
    end
  endtask

  // Advance one clock, keeping the model in lockstep; returns at the next negedge.
  task automatic step();
    logic acc, cons;
    expect_now();
    acc  = in_valid && exp_ready && reset_n;
    cons = exp_valid && out_ready && reset_n;
    @(posedge clk);
    model_step(acc, cons);
    @(negedge clk);
  endtask

  task automatic drain();
    in_valid = 1'b0;
    out_ready = 1'b1;
    #1;
    repeat (4) step();
  endtask

  task automatic drive(input logic [2:0] c, input logic [15:0] a, input logic [15:0] b,
                       input logic [3:0] ra, input logic [3:0] rb);
    in_valid = 1'b1;
    alu_control = c;
    op_a = a;
    op_b = b;
    rd_a = ra;
    rd_b = rb;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL rst_out_valid got %b expected 0", out_valid); end
    compared++; if (result !== 16'h0) begin mismatched++; $display("FAIL rst_result got %h expected 0000", result); end
    compared++; if (result_rd !== 4'h0) begin mismatched++; $display("FAIL rst_result_rd got %h expected 0", result_rd); end
    compared++; if (illegal !== 1'b0) begin mismatched++; $display("FAIL rst_illegal got %b expected 0", illegal); end
    compared++; if ({flag_z, flag_c, flag_v} !== 3'b000) begin mismatched++; $display("FAIL rst_flags got %b expected 000", {flag_z, flag_c, flag_v}); end
    compared++; if (in_ready !== 1'b1) begin mismatched++; $display("FAIL rst_in_ready got %b expected 1", in_ready); end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_add_sub_move();
    out_ready = 1'b1;
    drive(3'd0, 16'hFFFF, 16'h0001, 4'd3, 4'd0);
    #1;
    step();
    in_valid = 1'b0;
    #1;
    compared++; if (out_valid !== 1'b1) begin mismatched++; $display("FAIL add_valid got %b expected 1", out_valid); end
    compared++; if (result !== 16'h0000) begin mismatched++; $display("FAIL add_result got %h expected 0000", result); end
    compared++; if (result_rd !== 4'd3) begin mismatched++; $display("FAIL add_rd got %0d expected 3", result_rd); end
    compared++; if ({flag_z, flag_c, flag_v} !== (FLAGS ? 3'b110 : 3'b000)) begin mismatched++; $display("FAIL add_flags got %b expected %b", {flag_z, flag_c, flag_v}, FLAGS ? 3'b110 : 3'b000); end
    step();
    drive(3'd1, 16'h8000, 16'h0001, 4'd4, 4'd0);
    #1;
    step();
    drive(3'd2, 16'hDEAD, 16'h1234, 4'd5, 4'd0);
    #1;
    compared++; if (result !== 16'h7FFF) begin mismatched++; $display("FAIL sub_result got %h expected 7fff", result); end
    compared++; if ({flag_z, flag_c, flag_v} !== (FLAGS ? 3'b001 : 3'b000)) begin mismatched++; $display("FAIL sub_flags got %b expected %b", {flag_z, flag_c, flag_v}, FLAGS ? 3'b001 : 3'b000); end
    compared++; if (in_ready !== 1'b1) begin mismatched++; $display("FAIL sub_in_ready got %b expected 1", in_ready); end
    step();
    in_valid = 1'b0;
    #1;
    compared++; if (result !== 16'h1234 || result_rd !== 4'd5) begin mismatched++; $display("FAIL move_beat got %h/r%0d expected 1234/r5", result, result_rd); end
    compared++; if ({flag_z, flag_c, flag_v} !== (FLAGS ? 3'b001 : 3'b000)) begin mismatched++; $display("FAIL move_flags got %b expected %b", {flag_z, flag_c, flag_v}, FLAGS ? 3'b001 : 3'b000); end
    drain();
  endtask

  task automatic test_swap();
    out_ready = 1'b1;
    drive(3'd3, 16'hAAAA, 16'h5555, 4'd1, 4'd2);
    #1;
    compared++; if (in_ready !== 1'b1) begin mismatched++; $display("FAIL swap_accept_ready got %b expected 1", in_ready); end
    step();
    drive(3'd0, 16'h0001, 16'h0001, 4'd7, 4'd0);
    #1;
    compared++; if (out_valid !== 1'b1 || result !== 16'h5555 || result_rd !== 4'd1) begin mismatched++; $display("FAIL swap_beat0 got v%b %h/r%0d expected v1 5555/r1", out_valid, result, result_rd); end
    compared++; if (in_ready !== 1'b0) begin mismatched++; $display("FAIL swap1_in_ready got %b expected 0", in_ready); end
    step();
    compared++; if (out_valid !== 1'b1 || result !== 16'hAAAA || result_rd !== 4'd2) begin mismatched++; $display("FAIL swap_beat1 got v%b %h/r%0d expected v1 aaaa/r2", out_valid, result, result_rd); end
    compared++; if (in_ready !== 1'b0) begin mismatched++; $display("FAIL swap2_in_ready got %b expected 0", in_ready); end
    step();
    compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL swap_bubble_valid got %b expected 0", out_valid); end
    compared++; if (in_ready !== 1'b1) begin mismatched++; $display("FAIL swap_bubble_ready got %b expected 1", in_ready); end
    step();
    in_valid = 1'b0;
    #1;
    compared++; if (result !== 16'h0002 || result_rd !== 4'd7) begin mismatched++; $display("FAIL swap_after_add got %h/r%0d expected 0002/r7", result, result_rd); end
    drain();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    drive(3'd0, 16'd1, 16'd2, 4'd4, 4'd0);
    #1;
    step();
    drive(3'd0, 16'd10, 16'd20, 4'd5, 4'd0);
    for (int i = 0; i < 4; i++) begin
      #1;
      compared++; if (in_ready !== 1'b0) begin mismatched++; $display("FAIL stall_in_ready[%0d] got %b expected 0", i, in_ready); end
      compared++; if (out_valid !== 1'b1 || result !== 16'd3 || result_rd !== 4'd4) begin mismatched++; $display("FAIL stall_hold[%0d] got v%b %h/r%0d expected v1 0003/r4", i, out_valid, result, result_rd); end
      step();
    end
    out_ready = 1'b1;
    #1;
    compared++; if (in_ready !== 1'b1 || result !== 16'd3) begin mismatched++; $display("FAIL release_first got rdy%b %h expected rdy1 0003", in_ready, result); end
    step();
    drive(3'd0, 16'd100, 16'd200, 4'd6, 4'd0);
    #1;
    compared++; if (result !== 16'd30 || result_rd !== 4'd5) begin mismatched++; $display("FAIL release_second got %h/r%0d expected 001e/r5", result, result_rd); end
    step();
    in_valid = 1'b0;
    #1;
    compared++; if (result !== 16'd300 || result_rd !== 4'd6) begin mismatched++; $display("FAIL release_third got %h/r%0d expected 012c/r6", result, result_rd); end
    step();
    compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL release_empty got %b expected 0", out_valid); end
    drain();
  endtask

  task automatic test_illegal();
    out_ready = 1'b1;
    drive(3'd1, 16'h0000, 16'h0001, 4'd9, 4'd0);
    #1;
    step();
    drive(3'b110, 16'h1357, 16'h2468, 4'd11, 4'd12);
    #1;
    step();
    drive(3'd2, 16'h0000, 16'h0042, 4'd13, 4'd0);
    #1;
    compared++; if (illegal !== 1'b1 || result !== 16'h0 || result_rd !== 4'd11) begin mismatched++; $display("FAIL illegal_beat got i%b %h/r%0d expected i1 0000/r11", illegal, result, result_rd); end
    compared++; if ({flag_z, flag_c, flag_v} !== (FLAGS ? 3'b010 : 3'b000)) begin mismatched++; $display("FAIL illegal_flags got %b expected %b", {flag_z, flag_c, flag_v}, FLAGS ? 3'b010 : 3'b000); end
    step();
    in_valid = 1'b0;
    #1;
    compared++; if (illegal !== 1'b0 || result !== 16'h0042) begin mismatched++; $display("FAIL post_illegal got i%b %h expected i0 0042", illegal, result); end
    drain();
  endtask

  task automatic test_reset_mid_swap();
    out_ready = 1'b0;
    drive(3'd3, 16'h1111, 16'h2222, 4'd8, 4'd9);
    #1;
    step();
    in_valid = 1'b0;
    #1;
    compared++; if (out_valid !== 1'b1 || result !== 16'h2222) begin mismatched++; $display("FAIL midswap_beat0 got v%b %h expected v1 2222", out_valid, result); end
    reset_n = 1'b0;
    model_reset();
    #1;
    compared++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin mismatched++; $display("FAIL midswap_reset got v%b rdy%b expected v0 rdy1", out_valid, in_ready); end
    compared++; if ({flag_z, flag_c, flag_v} !== 3'b000 || result !== 16'h0) begin mismatched++; $display("FAIL midswap_clear got %b %h expected 000 0000", {flag_z, flag_c, flag_v}, result); end
    step();
    reset_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL midswap_no_beat1[%0d] got %b expected 0", i, out_valid); end
      step();
    end
  endtask

  function automatic logic [15:0] rand_op();
    case ($urandom_range(0, 4))
      0: return 16'h0000;
      1: return 16'hFFFF;
      2: return 16'h8000;
      3: return 16'h7FFF;
      default: return 16'($urandom_range(0, 65535));
    endcase
  endfunction

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 5) == 0) alu_control = 3'($urandom_range(4, 7));
      else alu_control = 3'($urandom_range(0, 3));
      op_a = rand_op();
      op_b = rand_op();
      rd_a = 4'($urandom_range(0, 15));
      rd_b = 4'($urandom_range(0, 15));
      #1;
      expect_now();
      compared++; if (in_ready !== exp_ready) begin mismatched++; $display("FAIL rnd_in_ready cyc %0d got %b expected %b", n, in_ready, exp_ready); end
      compared++; if (out_valid !== exp_valid) begin mismatched++; $display("FAIL rnd_out_valid cyc %0d got %b expected %b", n, out_valid, exp_valid); end
      if (exp_valid) begin
        compared++; if (result !== exp_data || result_rd !== exp_rd || illegal !== exp_ill) begin mismatched++; $display("FAIL rnd_beat cyc %0d got %h/r%0d/i%b expected %h/r%0d/i%b", n, result, result_rd, illegal, exp_data, exp_rd, exp_ill); end
      end
      compared++; if ({flag_z, flag_c, flag_v} !== exp_flags) begin mismatched++; $display("FAIL rnd_flags cyc %0d got %b expected %b", n, {flag_z, flag_c, flag_v}, exp_flags); end
      step();
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_add_sub_move();
    test_swap();
    test_back_to_back();
    test_illegal();
    test_reset_mid_swap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
